wb_pack_stage: RTL and testbench

- Writeback stage directly downstream of the MEM/WB pipeline register.
- Consumes the registered MEM/WB outputs and produces registered write strobes for the scalar register file and the vector (pixel) register file.
- Scalar results pass straight through.
- Byte loads destined for a vector register are packed lane by lane until a full vector word exists; only then is one vector write issued.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_pack_if.sv | 47 ++++
 rtl/vec_byte_packer.sv | 91 +++++++++
 rtl/wb_pack_stage.sv | 71 +++++++
 tb/tb_wb_pack_stage.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants, types and select encodings for the writeback stage.
// Used by wb_pack_if, vec_byte_packer and wb_pack_stage.
package wb_pkg;
  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int DW     = LANES * BYTE_W;
  localparam int AW     = 4;

  typedef logic [$clog2(LANES)-1:0] lane_cnt_t;

  localparam logic SEL_DAT_DO  = 1'b1;
  localparam logic SEL_DAT_ALU = 1'b0;
  localparam logic SEL_C_BYTE  = 1'b1;
  localparam logic SEL_C_WORD  = 1'b0;
endpackage

// File: rtl/wb_pack_if.sv
// MEM/WB contents into the writeback stage, RF write strobes out.
// fwd_* carry the EX bypass; they are only driven live under WB_FWD_EN.
interface wb_pack_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          PROHIB_WB;
  logic          SEL_DAT;
  logic          SEL_C;
  logic          WE_C;
  logic          WE_V;
  logic [DW-1:0] Do;
  logic [7:0]    Dob;
  logic [DW-1:0] ALU_Result;
  logic [AW-1:0] Rg;

  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          vrf_we;
  logic [AW-1:0] vrf_wa;
  logic [DW-1:0] vrf_wd;
  logic          pack_busy;
  logic          pack_abort;

  logic          fwd_valid;
  logic [AW-1:0] fwd_rg;
  logic [DW-1:0] fwd_data;

  modport master (
    output PROHIB_WB, SEL_DAT, SEL_C, WE_C, WE_V,
    output Do, Dob, ALU_Result, Rg,
    input  rf_we, rf_wa, rf_wd,
    input  vrf_we, vrf_wa, vrf_wd,
    input  pack_busy, pack_abort,
    input  fwd_valid, fwd_rg, fwd_data
  );

  modport slave (
    input  PROHIB_WB, SEL_DAT, SEL_C, WE_C, WE_V,
    input  Do, Dob, ALU_Result, Rg,
    output rf_we, rf_wa, rf_wd,
    output vrf_we, vrf_wa, vrf_wd,
    output pack_busy, pack_abort,
    output fwd_valid, fwd_rg, fwd_data
  );
endinterface

// File: rtl/vec_byte_packer.sv
// Packs byte loads into full vector words; whole-word writes pass through.
// A partial pack is dropped (pack_abort) when a new target preempts it.
module vec_byte_packer #(
  parameter int LANES = 4,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 we_v,
  input  logic                 sel_dat,
  input  logic [7:0]           dob,
  input  logic [LANES*8-1:0]   alu,
  input  logic [AW-1:0]        rg,
  output logic                 vrf_we,
  output logic [AW-1:0]        vrf_wa,
  output logic [LANES*8-1:0]   vrf_wd,
  output logic                 pack_busy,
  output logic                 pack_abort
);
  import wb_pkg::*;

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]            cnt, cnt_n;
  logic [LANES-1:0][7:0]    pbuf, pbuf_n;
  logic [AW-1:0]            pack_rg, pack_rg_n;
  logic                     we_n, abort_n;
  logic [AW-1:0]            wa_n;
  logic [LANES*8-1:0]       wd_n;
  logic                     hit;

  assign hit = (cnt != '0) && (rg == pack_rg);

  always_comb begin
    cnt_n     = cnt;
    pbuf_n    = pbuf;
    pack_rg_n = pack_rg;
    we_n      = 1'b0;
    abort_n   = 1'b0;
    wa_n      = vrf_wa;
    wd_n      = vrf_wd;
    if (accept && we_v) begin
      if (sel_dat == SEL_DAT_ALU) begin
        we_n    = 1'b1;
        wa_n    = rg;
        wd_n    = alu;
        abort_n = (cnt != '0);
        cnt_n   = '0;
      end else if (!hit) begin
        // first byte of a pack, or a new target preempting a partial one
        abort_n   = (cnt != '0);
        pbuf_n    = '0;
        pbuf_n[0] = dob;
        pack_rg_n = rg;
        cnt_n     = CW'(1);
      end else if (cnt == LAST) begin
        we_n  = 1'b1;
        wa_n  = pack_rg;
        wd_n  = {dob, pbuf[LANES-2:0]};
        cnt_n = '0;
      end else begin
        pbuf_n[cnt] = dob;
        cnt_n       = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      pbuf       <= '0;
      pack_rg    <= '0;
      vrf_we     <= 1'b0;
      vrf_wa     <= '0;
      vrf_wd     <= '0;
      pack_busy  <= 1'b0;
      pack_abort <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      pbuf       <= pbuf_n;
      pack_rg    <= pack_rg_n;
      vrf_we     <= we_n;
      vrf_wa     <= wa_n;
      vrf_wd     <= wd_n;
      pack_busy  <= (cnt_n != '0);
      pack_abort <= abort_n;
    end
  end
endmodule

// File: rtl/wb_pack_stage.sv
// Writeback stage: scalar RF strobes plus vector RF byte packing.
// Define WB_FWD_EN to drive the combinational EX bypass outputs.
module wb_pack_stage #(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input logic     clk,
  input logic     rst,
  wb_pack_if.slave bus
);
  import wb_pkg::*;

  logic [DW-1:0] scal_d;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  always_comb begin
    scal_d = bus.ALU_Result;
    if (bus.SEL_C == SEL_C_BYTE)
      scal_d = {{(DW-8){1'b0}}, bus.Dob};
    else if (bus.SEL_DAT == SEL_DAT_DO)
      scal_d = bus.Do;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= bus.WE_C & ~bus.PROHIB_WB;
      rf_wa <= bus.Rg;
      rf_wd <= scal_d;
    end
  end

  assign bus.rf_we = rf_we;
  assign bus.rf_wa = rf_wa;
  assign bus.rf_wd = rf_wd;

  vec_byte_packer #(
    .LANES (LANES),
    .AW    (AW)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (~bus.PROHIB_WB),
    .we_v       (bus.WE_V),
    .sel_dat    (bus.SEL_DAT),
    .dob        (bus.Dob),
    .alu        (bus.ALU_Result),
    .rg         (bus.Rg),
    .vrf_we     (bus.vrf_we),
    .vrf_wa     (bus.vrf_wa),
    .vrf_wd     (bus.vrf_wd),
    .pack_busy  (bus.pack_busy),
    .pack_abort (bus.pack_abort)
  );

`ifdef WB_FWD_EN
  assign bus.fwd_valid = bus.WE_C & ~bus.PROHIB_WB;
  assign bus.fwd_rg    = bus.Rg;
  assign bus.fwd_data  = scal_d;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rg    = '0;
  assign bus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_wb_pack_stage.sv
// Directed vector bench for wb_pack_stage.
// Table of single-cycle records plus a reset-mid-pack sequence.
module tb_wb_pack_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_pack_if #(.DW(32), .AW(4)) bus ();

  wb_pack_stage #(.LANES(4), .DW(32), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        p, sd, sc, wc, wv;
    logic [31:0] d;
    logic [7:0]  dob;
    logic [31:0] alu;
    logic [3:0]  rg;
    logic        e_rw;
    logic [3:0]  e_rwa;
    logic [31:0] e_rwd;
    logic        e_vw;
    logic [3:0]  e_vwa;
    logic [31:0] e_vwd;
    logic        e_busy, e_abort;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic p, sd, sc, wc, wv,
    input logic [31:0] d, input logic [7:0] dob,
    input logic [31:0] alu, input logic [3:0] rg,
    input logic rw, input logic [3:0] rwa, input logic [31:0] rwd,
    input logic vw, input logic [3:0] vwa, input logic [31:0] vwd,
    input logic b, input logic a);
    vec_t v;
    v.p = p; v.sd = sd; v.sc = sc; v.wc = wc; v.wv = wv;
    v.d = d; v.dob = dob; v.alu = alu; v.rg = rg;
    v.e_rw = rw; v.e_rwa = rwa; v.e_rwd = rwd;
    v.e_vw = vw; v.e_vwa = vwa; v.e_vwd = vwd;
    v.e_busy = b; v.e_abort = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.PROHIB_WB  = v.p;
    bus.SEL_DAT    = v.sd;
    bus.SEL_C      = v.sc;
    bus.WE_C       = v.wc;
    bus.WE_V       = v.wv;
    bus.Do         = v.d;
    bus.Dob        = v.dob;
    bus.ALU_Result = v.alu;
    bus.Rg         = v.rg;
  endtask

  task automatic check_out(input string t, input vec_t v);
    chk({t, ".rf_we"},      64'(bus.rf_we),      64'(v.e_rw));
    chk({t, ".rf_wa"},      64'(bus.rf_wa),      64'(v.e_rwa));
    chk({t, ".rf_wd"},      64'(bus.rf_wd),      64'(v.e_rwd));
    chk({t, ".vrf_we"},     64'(bus.vrf_we),     64'(v.e_vw));
    chk({t, ".vrf_wa"},     64'(bus.vrf_wa),     64'(v.e_vwa));
    chk({t, ".vrf_wd"},     64'(bus.vrf_wd),     64'(v.e_vwd));
    chk({t, ".pack_busy"},  64'(bus.pack_busy),  64'(v.e_busy));
    chk({t, ".pack_abort"}, 64'(bus.pack_abort), 64'(v.e_abort));
  endtask

  task automatic step(input string t, input vec_t v);
    logic        f_v;
    logic [31:0] f_d;
    drive(v);
    #1;
`ifdef WB_FWD_EN
    f_v = v.wc & ~v.p;
    f_d = v.sc ? {24'h0, v.dob} : (v.sd ? v.d : v.alu);
    chk({t, ".fwd_rg"}, 64'(bus.fwd_rg), 64'(v.rg));
`else
    f_v = 1'b0;
    f_d = 32'h0;
`endif
    chk({t, ".fwd_valid"}, 64'(bus.fwd_valid), 64'(f_v));
    chk({t, ".fwd_data"},  64'(bus.fwd_data),  64'(f_d));
    @(posedge clk);
    #1;
    check_out(t, v);
  endtask

  localparam logic [31:0] D = 32'hCAFEF00D;

  initial begin
    vec_t z;
    z = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0);
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", z);
    rst = 1'b0;

    // scalar path
    vq.push_back(mk(0,0,0,1,0, D,8'h7F,32'hDEADBEEF,5, 1,5,32'hDEADBEEF, 0,0,0, 0,0));
    vq.push_back(mk(0,0,1,1,0, D,8'h7F,32'hDEADBEEF,5, 1,5,32'h7F, 0,0,0, 0,0));
    vq.push_back(mk(0,1,0,1,0, D,8'h7F,32'hDEADBEEF,7, 1,7,D, 0,0,0, 0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,32'h11111111,8, 0,8,32'h11111111, 0,0,0, 0,0));
    vq.push_back(mk(1,0,0,1,0, 0,0,32'h22222222,8, 0,8,32'h22222222, 0,0,0, 0,0));
    // full pack to r2
    vq.push_back(mk(0,1,0,0,1, 0,8'h01,0,2, 0,2,0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h02,0,2, 0,2,0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h03,0,2, 0,2,0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h04,0,2, 0,2,0, 1,2,32'h04030201, 0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,2,32'h04030201, 0,0));
    // bubble mid-pack to r1
    vq.push_back(mk(0,1,0,0,1, 0,8'hAA,0,1, 0,1,0, 0,2,32'h04030201, 1,0));
    vq.push_back(mk(1,1,0,0,1, 0,8'hFF,0,1, 0,1,0, 0,2,32'h04030201, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'hBB,0,1, 0,1,0, 0,2,32'h04030201, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'hCC,0,1, 0,1,0, 0,2,32'h04030201, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'hDD,0,1, 0,1,0, 1,1,32'hDDCCBBAA, 0,0));
    // preempting pack: r4 abandoned for r6
    vq.push_back(mk(0,1,0,0,1, 0,8'h10,0,4, 0,4,0, 0,1,32'hDDCCBBAA, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h20,0,4, 0,4,0, 0,1,32'hDDCCBBAA, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h55,0,6, 0,6,0, 0,1,32'hDDCCBBAA, 1,1));
    vq.push_back(mk(0,1,0,0,1, 0,8'h66,0,6, 0,6,0, 0,1,32'hDDCCBBAA, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h77,0,6, 0,6,0, 0,1,32'hDDCCBBAA, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h88,0,6, 0,6,0, 1,6,32'h88776655, 0,0));
    // scalar and whole-word vector together
    vq.push_back(mk(0,0,0,1,1, 0,0,32'h12345678,9, 1,9,32'h12345678, 1,9,32'h12345678, 0,0));
    // whole-word write discards a partial pack
    vq.push_back(mk(0,1,0,0,1, 0,8'hA1,0,3, 0,3,0, 0,9,32'h12345678, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'hA2,0,3, 0,3,0, 0,9,32'h12345678, 1,0));
    vq.push_back(mk(0,0,0,0,1, 0,0,32'hCAFE0001,10, 0,10,32'hCAFE0001, 1,10,32'hCAFE0001, 0,1));
    // scalar traffic interleaved into a pack
    vq.push_back(mk(0,1,0,0,1, 0,8'h01,0,12, 0,12,0, 0,10,32'hCAFE0001, 1,0));
    vq.push_back(mk(0,0,0,1,0, 0,0,32'h5,13, 1,13,32'h5, 0,10,32'hCAFE0001, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h02,0,12, 0,12,0, 0,10,32'hCAFE0001, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h03,0,12, 0,12,0, 0,10,32'hCAFE0001, 1,0));
    vq.push_back(mk(0,1,0,0,1, 0,8'h04,0,12, 0,12,0, 1,12,32'h04030201, 0,0));

    foreach (vq[i]) step($sformatf("v%0d", i), vq[i]);

    // reset in the middle of a pack
    step("rp0", mk(0,1,0,0,1, 0,8'h11,0,3, 0,3,0, 0,12,32'h04030201, 1,0));
    step("rp1", mk(0,1,0,0,1, 0,8'h22,0,3, 0,3,0, 0,12,32'h04030201, 1,0));
    rst = 1'b1;
    drive(mk(0,1,0,1,1, 0,8'h99,0,3, 0,0,0, 0,0,0, 0,0));
    @(posedge clk);
    #1;
    check_out("rst_mid", z);
    rst = 1'b0;
    step("rp2", mk(0,1,0,0,1, 0,8'h33,0,3, 0,3,0, 0,0,0, 1,0));
    step("rp3", mk(0,1,0,0,1, 0,8'h44,0,3, 0,3,0, 0,0,0, 1,0));
    step("rp4", mk(0,1,0,0,1, 0,8'h55,0,3, 0,3,0, 0,0,0, 1,0));
    step("rp5", mk(0,1,0,0,1, 0,8'h66,0,3, 0,3,0, 1,3,32'h66554433, 0,0));
    step("rp6", mk(0,0,0,0,0, 0,0,0,3, 0,3,0, 0,3,32'h66554433, 0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
